flight_timer: RTL

- Consumes the 0.1 s square wave from the clock divider and produces an elapsed-flight-time readout, mm:ss.t in BCD, for the seven-segment score display.
- Synchronises the slow wave into the clk domain and detects its rising edges as one-cycle ticks.
- Counts ticks under start/pause/game-over control.
- Raises a sticky fault if the slow wave stops toggling while the timer is running.

---
 rtl/flight_timer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/flight_timer.sv
// Elapsed flight-time counter: synchronises the 0.1 s wave, counts its rising edges
// as mm:ss.t BCD under start/pause/game-over control, with a lost-tick watchdog.
module flight_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 15000000,
  parameter int unsigned WD_W           = 24
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       clk10,
  input  logic       start,
  input  logic       pause,
  input  logic       game_over,
  output logic       tick,
  output logic [3:0] tenths,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       overflow,
  output logic       tick_lost
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, STOP} state_e;

  state_e          state_q, state_d;
  logic            s1_q, s2_q, s3_q, tick_q;
  logic [3:0]      tenths_q, sec_ones_q, sec_tens_q, min_ones_q, min_tens_q;
  logic [3:0]      tenths_d, sec_ones_d, sec_tens_d, min_ones_d, min_tens_d;
  logic            running_q, running_d, overflow_q, overflow_d, tick_lost_q, tick_lost_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            rise, active, stop_ev, clear_ev, toggle_ev, count_ev, saturated;

  // Synchroniser resets high to match the divider, so reset never yields a tick
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      s3_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      s1_q   <= clk10;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      tick_q <= rise;
    end
  end

  assign rise      = s2_q & ~s3_q;
  assign active    = (state_q == RUN) || (state_q == PAUSE);
  assign stop_ev   = game_over & active;
  assign clear_ev  = start & ~stop_ev;
  assign toggle_ev = pause & ~game_over & ~start & active;
  assign count_ev  = (state_q == RUN) & rise & ~game_over & ~start & ~pause;
  assign saturated = (min_tens_q == 4'd5) && (min_ones_q == 4'd9) && (sec_tens_q == 4'd5)
                     && (sec_ones_q == 4'd9) && (tenths_q == 4'd9);

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: game_over beats start beats pause
  always_comb begin
    state_d = state_q;
    if (stop_ev)                    state_d = STOP;
    else if (clear_ev)              state_d = RUN;
    else if (toggle_ev)             state_d = (state_q == RUN) ? PAUSE : RUN;
    else if (count_ev && saturated) state_d = STOP;
  end

  // Output / datapath next values
  always_comb begin
    tenths_d    = tenths_q;
    sec_ones_d  = sec_ones_q;
    sec_tens_d  = sec_tens_q;
    min_ones_d  = min_ones_q;
    min_tens_d  = min_tens_q;
    overflow_d  = overflow_q;
    tick_lost_d = tick_lost_q;
    wd_d        = wd_q;
    running_d   = (state_d == RUN);
    if (clear_ev) begin
      tenths_d    = 4'd0;
      sec_ones_d  = 4'd0;
      sec_tens_d  = 4'd0;
      min_ones_d  = 4'd0;
      min_tens_d  = 4'd0;
      overflow_d  = 1'b0;
      tick_lost_d = 1'b0;
      wd_d        = '0;
    end else if (state_q == PAUSE && state_d == RUN) begin
      wd_d = '0;
    end else if (count_ev) begin
      wd_d = '0;
      if (saturated) begin
        overflow_d = 1'b1;
      end else if (tenths_q != 4'd9) begin
        tenths_d = tenths_q + 4'd1;
      end else begin
        // Full ripple carry resolves in this single cycle
        tenths_d = 4'd0;
        if (sec_ones_q != 4'd9) begin
          sec_ones_d = sec_ones_q + 4'd1;
        end else begin
          sec_ones_d = 4'd0;
          if (sec_tens_q != 4'd5) begin
            sec_tens_d = sec_tens_q + 4'd1;
          end else begin
            sec_tens_d = 4'd0;
            if (min_ones_q != 4'd9) begin
              min_ones_d = min_ones_q + 4'd1;
            end else begin
              min_ones_d = 4'd0;
              min_tens_d = min_tens_q + 4'd1;
            end
          end
        end
      end
    end else if (state_q == RUN && state_d == RUN) begin
      if (wd_q != WD_W'(TIMEOUT_CYCLES)) begin
        wd_d = wd_q + WD_W'(1);
        if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) tick_lost_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tenths_q    <= 4'd0;
      sec_ones_q  <= 4'd0;
      sec_tens_q  <= 4'd0;
      min_ones_q  <= 4'd0;
      min_tens_q  <= 4'd0;
      running_q   <= 1'b0;
      overflow_q  <= 1'b0;
      tick_lost_q <= 1'b0;
      wd_q        <= '0;
    end else begin
      tenths_q    <= tenths_d;
      sec_ones_q  <= sec_ones_d;
      sec_tens_q  <= sec_tens_d;
      min_ones_q  <= min_ones_d;
      min_tens_q  <= min_tens_d;
      running_q   <= running_d;
      overflow_q  <= overflow_d;
      tick_lost_q <= tick_lost_d;
      wd_q        <= wd_d;
    end
  end

  assign tick      = tick_q;
  assign tenths    = tenths_q;
  assign sec_ones  = sec_ones_q;
  assign sec_tens  = sec_tens_q;
  assign min_ones  = min_ones_q;
  assign min_tens  = min_tens_q;
  assign running   = running_q;
  assign overflow  = overflow_q;
  assign tick_lost = tick_lost_q;

endmodule
